instruction_sequencer: RTL and testbench

- Generates the 2-bit `state` phase consumed by control_matrix.
- Sequences each instruction through fetch (phase 0) and only as many execute phases as its opcode needs.
- Handles start/launch, memory stalls, single-step and halt requests, illegal-opcode trap, and retired-instruction counting.
- Sits between the front-panel/top-level controls and control_matrix; owns the program-start PC reset pulse.

---
 rtl/instruction_sequencer.sv | 177 +++++++++++++++++
 tb/tb_instruction_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_sequencer
//
// Purpose:
//   Produces the 2-bit execution phase (`state`) that drives control_matrix.
//   Each instruction gets a fetch phase (0), followed by only as many execute
//   phases as its opcode needs. The block also handles the following:
//     - program launch and the one-cycle PC reset pulse
//     - memory stalls
//     - single-step pausing
//     - halt requests
//     - the illegal-opcode trap
//     - counting retired instructions
//
// Ports:
//   clock        system clock
//   reset_n      synchronous reset, active-low
//   start        start/restart request (level, sampled every clock)
//   opcode       current instruction opcode from program memory
//   mem_busy     memory not ready; freezes execute phases 1-3
//   step_mode    1 = pause after each retired instruction
//   step         resume one instruction while paused
//   halt_req     stop once the current instruction retires
//   state        phase to control_matrix (0 outside RUN)
//   pc_reset     one-cycle PC reset while launching
//   running      sequencer is in LAUNCH or RUN
//   halted       sequencer is in HALT
//   illegal_op   sticky: the last halt came from an opcode with bit 3 set
//   instr_done   one-cycle pulse after each retired instruction
//   instr_count  retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module instruction_sequencer #(
    parameter int CNTW = 16,
    parameter int OPW  = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [OPW-1:0]  opcode,
    input  logic            mem_busy,
    input  logic            step_mode,
    input  logic            step,
    input  logic            halt_req,
    output logic [1:0]      state,
    output logic            pc_reset,
    output logic            running,
    output logic            halted,
    output logic            illegal_op,
    output logic            instr_done,
    output logic [CNTW-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_PAUSE,
        S_HALT
    } seq_state_t;

    seq_state_t      fsm_q, fsm_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      op_q, op_d;        // only the low bits select the length
    logic [CNTW-1:0] count_q, count_d;
    logic            done_q, done_d;
    logic            illegal_q, illegal_d;
    logic [1:0]      last_phase;

    // Final execute phase for each legal opcode. The opcode is latched when
    // the sequencer leaves phase 0, so a later change on the memory bus
    // cannot change the length of the instruction.
    always_comb begin
        case (op_q)
            3'b000, 3'b001: last_phase = 2'd1;  // OUT, JMP
            3'b100, 3'b101: last_phase = 2'd2;  // RTR, BLT
            default:        last_phase = 2'd3;  // LDW, STW, ADD, SUB
        endcase
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        fsm_d     = fsm_q;
        phase_d   = phase_q;
        op_d      = op_q;
        count_d   = count_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;

        case (fsm_q)
            S_IDLE: begin
                if (start) fsm_d = S_LAUNCH;
            end

            S_LAUNCH: begin
                fsm_d   = S_RUN;
                phase_d = 2'd0;
                count_d = '0;
            end

            S_RUN: begin
                if (phase_q == 2'd0) begin
                    // Fetch ignores mem_busy. The opcode is captured here.
                    op_d = opcode[2:0];
                    if (opcode[OPW-1]) begin
                        fsm_d     = S_HALT;
                        illegal_d = 1'b1;
                    end else begin
                        phase_d = 2'd1;
                    end
                end else if (!mem_busy) begin
                    if (phase_q == last_phase) begin
                        // Retire. halt_req and step_mode are only examined here.
                        count_d = count_q + CNTW'(1);
                        done_d  = 1'b1;
                        phase_d = 2'd0;
                        if (halt_req) begin
                            fsm_d     = S_HALT;
                            illegal_d = 1'b0;
                        end else if (step_mode) begin
                            fsm_d = S_PAUSE;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end

            S_PAUSE: begin
                if (start) begin
                    fsm_d = S_LAUNCH;
                end else if (step) begin
                    fsm_d   = S_RUN;
                    phase_d = 2'd0;
                end
            end

            S_HALT: begin
                if (start) begin
                    fsm_d     = S_LAUNCH;
                    illegal_d = 1'b0;
                end
            end

            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments, so every
        // register samples the values from before the edge.
        if (!reset_n) begin
            fsm_q     <= S_IDLE;
            phase_q   <= 2'd0;
            op_q      <= 3'd0;
            count_q   <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            phase_q   <= phase_d;
            op_q      <= op_d;
            count_q   <= count_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign state       = (fsm_q == S_RUN) ? phase_q : 2'd0;
    assign pc_reset    = (fsm_q == S_LAUNCH);
    assign running     = (fsm_q == S_LAUNCH) || (fsm_q == S_RUN);
    assign halted      = (fsm_q == S_HALT);
    assign illegal_op  = illegal_q;
    assign instr_done  = done_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instruction_sequencer
//
// Purpose:
//   Self-checking bench for instruction_sequencer. The counter is 4 bits wide
//   so that wrap-around is reachable.
//
//   The bench first runs directed steps:
//     - reset and launch
//     - per-opcode instruction lengths
//     - a memory stall
//     - the illegal-opcode trap
//     - single-step and halt
//
//   It then runs a randomised instruction stream. That stream is predicted
//   instruction by instruction from the opcode length table. Finally it
//   applies reset in the middle of a stalled instruction.
//
//   Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_instruction_sequencer;

    localparam int CNTW = 4;

    logic            clock = 1'b0;
    logic            reset_n, start, mem_busy, step_mode, step, halt_req;
    logic [3:0]      opcode;
    logic [1:0]      state;
    logic            pc_reset, running, halted, illegal_op, instr_done;
    logic [CNTW-1:0] instr_count;

    int checks = 0;
    int fails  = 0;

    instruction_sequencer #(.CNTW(CNTW), .OPW(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .opcode      (opcode),
        .mem_busy    (mem_busy),
        .step_mode   (step_mode),
        .step        (step),
        .halt_req    (halt_req),
        .state       (state),
        .pc_reset    (pc_reset),
        .running     (running),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .instr_done  (instr_done),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    // Number of execute phases per legal opcode: OUT JMP LDW STW RTR BLT ADD SUB
    int last_of [8] = '{1, 1, 3, 3, 2, 2, 3, 3};

    // Driven on the opcode bus after phase 0. It has bit 3 set and a short
    // length, so it is caught if the DUT reads the live bus instead of the
    // captured opcode.
    localparam logic [3:0] GARBAGE = 4'b1001;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output vector: {state, pc_reset, running, halted, illegal_op, instr_done, instr_count}
    function automatic logic [15:0] outs();
        return {5'b0, state, pc_reset, running, halted, illegal_op, instr_done, instr_count};
    endfunction

    function automatic logic [15:0] expv(int st, bit pc, bit run, bit hlt, bit ill, bit dn, int cnt);
        return {5'b0, 2'(st), pc, run, hlt, ill, dn, 4'(cnt)};
    endfunction

    int st_seq  [9] = '{0, 1, 0, 1, 2, 0, 1, 2, 3};
    int dn_seq  [9] = '{1, 0, 1, 0, 0, 1, 0, 0, 0};
    int cnt_seq [9] = '{1, 1, 2, 2, 2, 3, 3, 3, 3};
    logic [3:0] op_seq [9] = '{4'b0000, GARBAGE, 4'b0100, GARBAGE, GARBAGE,
                               4'b0011, GARBAGE, GARBAGE, GARBAGE};

    int st_ldw   [7] = '{0, 1, 2, 2, 2, 2, 3};
    int busy_ldw [7] = '{1, 0, 1, 1, 1, 0, 0};

    initial begin
        int model_cnt;
        bit pend_done;

        reset_n = 1'b0; start = 1'b0; opcode = 4'b0; mem_busy = 1'b0;
        step_mode = 1'b0; step = 1'b0; halt_req = 1'b0;
        tick(); tick();
        check("reset", outs(), expv(0, 0, 0, 0, 0, 0, 0));

        // Launch followed by one ADD.
        reset_n = 1'b1; start = 1'b1;
        tick();
        check("launch", outs(), expv(0, 1, 1, 0, 0, 0, 0));
        start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            tick();
            check($sformatf("add_ph%0d", p), outs(), expv(p, 0, 1, 0, 0, 0, 0));
            opcode = (p == 0) ? 4'b0110 : GARBAGE;
        end

        // OUT, RTR, STW back to back.
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("stream_%0d", i), outs(),
                  expv(st_seq[i], 0, 1, 0, 0, dn_seq[i] != 0, cnt_seq[i]));
            opcode = op_seq[i];
        end

        // LDW with a 3-cycle stall in phase 2. mem_busy in phase 0 is ignored.
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("ldw_%0d", i), outs(), expv(st_ldw[i], 0, 1, 0, 0, i == 0, 4));
            opcode   = (i == 0) ? 4'b0010 : GARBAGE;
            mem_busy = busy_ldw[i] != 0;
        end

        // Illegal opcode trap.
        tick();
        check("ldw_retire", outs(), expv(0, 0, 1, 0, 0, 1, 5));
        opcode = 4'b1010;
        tick();
        check("trap", outs(), expv(0, 0, 0, 1, 1, 0, 5));
        mem_busy = 1'b1;
        tick();
        check("trap_hold", outs(), expv(0, 0, 0, 1, 1, 0, 5));
        start = 1'b1; mem_busy = 1'b0;
        tick();
        check("relaunch", outs() >> 4, expv(0, 1, 1, 0, 0, 0, 0) >> 4);
        start = 1'b0; step_mode = 1'b1;

        // Single-step: JMP pauses, one step runs OUT, which pauses again.
        tick();
        check("jmp_ph0", outs(), expv(0, 0, 1, 0, 0, 0, 0));
        opcode = 4'b0001;
        tick();
        check("jmp_ph1", outs(), expv(1, 0, 1, 0, 0, 0, 0));
        opcode = GARBAGE;
        tick();
        check("pause", outs(), expv(0, 0, 0, 0, 0, 1, 1));
        mem_busy = 1'b1;
        tick();
        check("pause_hold", outs(), expv(0, 0, 0, 0, 0, 0, 1));
        mem_busy = 1'b0; step = 1'b1;
        tick();
        check("step_ph0", outs(), expv(0, 0, 1, 0, 0, 0, 1));
        step = 1'b0; opcode = 4'b0000;
        tick();
        check("step_ph1", outs(), expv(1, 0, 1, 0, 0, 0, 1));
        opcode = GARBAGE;
        tick();
        check("pause2", outs(), expv(0, 0, 0, 0, 0, 1, 2));
        step = 1'b1;

        // halt_req raised mid-ADD takes effect only at retire.
        tick();
        check("halt_ph0", outs(), expv(0, 0, 1, 0, 0, 0, 2));
        step = 1'b0; step_mode = 1'b0; opcode = 4'b0110;
        for (int p = 1; p < 4; p++) begin
            tick();
            check($sformatf("halt_ph%0d", p), outs(), expv(p, 0, 1, 0, 0, 0, 2));
            opcode = GARBAGE; halt_req = 1'b1;
        end
        tick();
        check("halt_req", outs(), expv(0, 0, 0, 1, 0, 1, 3));
        halt_req = 1'b0; start = 1'b1;
        tick();
        check("relaunch2", outs() >> 4, expv(0, 1, 1, 0, 0, 0, 0) >> 4);
        start = 1'b0; step_mode = 1'b1;
        tick();
        check("jmp2_ph0", outs(), expv(0, 0, 1, 0, 0, 0, 0));
        opcode = 4'b0001;
        tick();
        opcode = GARBAGE;
        tick();
        check("pause3", outs(), expv(0, 0, 0, 0, 0, 1, 1));

        // In PAUSE, start takes priority over step.
        start = 1'b1; step = 1'b1;
        tick();
        check("pause_start", outs() >> 4, expv(0, 1, 1, 0, 0, 0, 0) >> 4);
        start = 1'b0; step = 1'b0; step_mode = 1'b0;

        // Randomised stream, predicted one instruction at a time. Noise on
        // start, step, step_mode and halt_req only appears where it must be
        // ignored.
        model_cnt = 0;
        pend_done = 1'b0;
        for (int n = 0; n < 36; n++) begin
            int op;
            op = $urandom_range(0, 7);
            for (int p = 0; p <= last_of[op]; p++) begin
                int stalls;
                stalls = (p == 0) ? 0 : $urandom_range(0, 2);
                for (int s = 0; s <= stalls; s++) begin
                    bit retire;
                    retire = (p == last_of[op]) && (s == stalls);
                    tick();
                    if (p == 0 && n == 16)
                        check("wrap", {12'b0, instr_count}, 16'(model_cnt));
                    check($sformatf("rand_i%0d_p%0d_s%0d", n, p, s), outs(),
                          expv(p, 0, 1, 0, 0, pend_done, model_cnt));
                    pend_done = 1'b0;
                    opcode    = (p == 0) ? 4'(op) : 4'($urandom);
                    start     = 1'($urandom);
                    step      = 1'($urandom);
                    mem_busy  = (p == 0) ? 1'($urandom) : (s != stalls);
                    halt_req  = retire ? 1'b0 : 1'($urandom);
                    step_mode = retire ? 1'b0 : 1'($urandom);
                    if (retire) begin
                        model_cnt = (model_cnt + 1) % 16;
                        pend_done = 1'b1;
                    end
                end
            end
        end

        // Reset in phase 2 of a stalled LDW.
        tick();
        check("pre_rst_ph0", outs(), expv(0, 0, 1, 0, 0, pend_done, model_cnt));
        opcode = 4'b0010; start = 1'b0; step = 1'b0; mem_busy = 1'b0;
        halt_req = 1'b0; step_mode = 1'b0;
        tick();
        opcode = GARBAGE;
        tick();
        check("pre_rst_ph2", outs(), expv(2, 0, 1, 0, 0, 0, model_cnt));
        mem_busy = 1'b1; reset_n = 1'b0;
        tick();
        check("mid_op_reset", outs(), expv(0, 0, 0, 0, 0, 0, 0));
        start = 1'b1;
        tick();
        check("reset_over_start", outs(), expv(0, 0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
